// File: rtl/pivot_sequencer.sv
// Sequences pivot iterations: clears the pivot finder, streams the N x N matrix to it,
// waits (with timeout) for the pivot {i,j}, then hands it to the matrix updater.
module pivot_sequencer #(
  parameter int WIDTH    = 16,
  parameter int N_STOCKS = 4,
  parameter int MAX_ITER = 8,
  parameter int TIMEOUT  = 16,
  localparam int IW = $clog2(N_STOCKS),
  localparam int AW = $clog2(N_STOCKS * N_STOCKS),
  localparam int CW = $clog2(MAX_ITER + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CW-1:0]    n_iter,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             piv_rst,
  output logic             piv_valid,
  output logic [WIDTH-1:0] piv_data,
  input  logic             piv_ov,
  input  logic [2*IW-1:0]  piv_od,
  output logic             upd_req,
  output logic [IW-1:0]    upd_i,
  output logic [IW-1:0]    upd_j,
  input  logic             upd_ack,
  output logic [CW-1:0]    iter_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N_STOCKS * N_STOCKS - 1);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_ITER);
  localparam logic [TW-1:0] TMO_CNT   = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, CLR, READ, WAIT, UPDATE, FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            valid_q, valid_d;
  logic [CW-1:0]   n_lat_q, n_lat_d;
  logic [CW-1:0]   iter_q, iter_d;
  logic            err_q, err_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [IW-1:0]   upd_i_q, upd_i_d;
  logic [IW-1:0]   upd_j_q, upd_j_d;
  logic [CW-1:0]   n_clamped;
  logic [CW-1:0]   iter_inc;

  assign n_clamped = (n_iter > MAX_CNT) ? MAX_CNT : n_iter;
  assign iter_inc  = iter_q + CW'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    n_lat_d = n_lat_q;
    iter_d  = iter_q;
    err_d   = err_q;
    tcnt_d  = tcnt_q;
    upd_i_d = upd_i_q;
    upd_j_d = upd_j_q;
    // Read data returns one cycle after its address, so the beat trails READ by a cycle.
    valid_d = (state_q == READ);

    case (state_q)
      IDLE: begin
        if (start) begin
          n_lat_d = n_clamped;
          iter_d  = '0;
          err_d   = 1'b0;
          state_d = (n_clamped == '0) ? FINISH : CLR;
        end
      end
      CLR: begin
        addr_d  = '0;
        state_d = READ;
      end
      READ: begin
        addr_d = addr_q + AW'(1);
        if (addr_q == LAST_ADDR) begin
          tcnt_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A result arriving on the limit cycle still wins over the timeout.
        if (piv_ov) begin
          upd_i_d = piv_od[2*IW-1:IW];
          upd_j_d = piv_od[IW-1:0];
          state_d = UPDATE;
        end else if (tcnt_q == TMO_CNT) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      UPDATE: begin
        if (upd_ack) begin
          iter_d  = iter_inc;
          state_d = (iter_inc == n_lat_q) ? FINISH : CLR;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      n_lat_q <= '0;
      iter_q  <= '0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
      upd_i_q <= '0;
      upd_j_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      n_lat_q <= n_lat_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
      upd_i_q <= upd_i_d;
      upd_j_q <= upd_j_d;
    end
  end

  // Outputs are forced to their reset values while rst is held, whatever the state.
  always_comb begin
    busy      = !rst && (state_q != IDLE);
    done      = !rst && (state_q == FINISH);
    err       = !rst && err_q;
    piv_rst   = rst || (state_q == CLR);
    piv_valid = !rst && valid_q;
    piv_data  = piv_valid ? mem_rdata : '0;
    mem_addr  = (!rst && (state_q == READ)) ? addr_q : '0;
    upd_req   = !rst && (state_q == UPDATE);
    upd_i     = rst ? '0 : upd_i_q;
    upd_j     = rst ? '0 : upd_j_q;
    iter_cnt  = rst ? '0 : iter_q;
  end

endmodule

// File: tb/tb_pivot_sequencer.sv
// Scoreboard bench for pivot_sequencer: stimulus pushes expected beats/updates/done
// records, a negedge monitor pops and compares them as the DUT produces them.
module tb_pivot_sequencer;

  localparam int WIDTH    = 16;
  localparam int N        = 4;
  localparam int MAX_ITER = 8;
  localparam int TIMEOUT  = 16;
  localparam int IW       = 2;
  localparam int AW       = 4;
  localparam int CW       = 4;
  localparam int NN       = N * N;
  localparam int BUDGET   = 2000;

  localparam int EV_BEAT = 0;
  localparam int EV_UPD  = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CW-1:0]    n_iter = '0;
  logic             busy, done, err;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_rdata = '0;
  logic             piv_rst, piv_valid;
  logic [WIDTH-1:0] piv_data;
  logic             piv_ov = 1'b0;
  logic [2*IW-1:0]  piv_od = '0;
  logic             upd_req;
  logic [IW-1:0]    upd_i, upd_j;
  logic             upd_ack = 1'b0;
  logic [CW-1:0]    iter_cnt;

  pivot_sequencer #(
    .WIDTH(WIDTH), .N_STOCKS(N), .MAX_ITER(MAX_ITER), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .n_iter(n_iter),
    .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .piv_rst(piv_rst), .piv_valid(piv_valid), .piv_data(piv_data),
    .piv_ov(piv_ov), .piv_od(piv_od),
    .upd_req(upd_req), .upd_i(upd_i), .upd_j(upd_j), .upd_ack(upd_ack),
    .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  ev_t exp_q[$];

  logic [WIDTH-1:0] mem_arr [NN];
  bit   piv_on = 1'b1;
  bit   inject_ack = 1'b0;
  bit   ack_seen_q = 1'b0;

  int beats_seen = 0;
  int piv_rst_cnt = 0;
  int upd_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_beat_cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Matrix memory with 1-cycle read latency; the maximum 0x0100 sits at address 6.
  initial begin
    for (int a = 0; a < NN; a++) mem_arr[a] = (a == 6) ? 16'h0100 : WIDTH'(a * 5 + 3);
  end
  always @(posedge clk) mem_rdata <= mem_arr[mem_addr];

  always @(posedge clk) ack_seen_q <= upd_ack && upd_req && !rst;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic popExpect(input int kind, output ev_t e, output bit ok);
    ok = 1'b0;
    e = '{kind: -1, a: 0, b: 0};
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected event: got kind %0d, expected none (cycle %0d)", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      checkOutput("event kind", kind, e.kind);
      ok = (e.kind == kind);
    end
  endtask

  // Pivot-finder model: answers {2,1} on the third cycle after the last beat of a sweep.
  initial begin
    int beats = 0;
    int cd = -1;
    forever begin
      @(negedge clk);
      piv_ov = 1'b0;
      if (piv_rst) begin
        beats = 0;
        cd = -1;
      end else if (piv_valid) begin
        beats++;
        if (beats == NN && piv_on) cd = 3;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          piv_ov = 1'b1;
          piv_od = {2'd2, 2'd1};
          cd = -1;
        end
      end
    end
  end

  // Matrix-updater model: acknowledges two cycles after a request appears.
  initial begin
    int cd = -1;
    bit fire;
    forever begin
      @(negedge clk);
      fire = 1'b0;
      if (rst) cd = -1;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          fire = 1'b1;
          cd = -1;
        end
      end else if (upd_req) cd = 2;
      upd_ack = fire || inject_ack;
    end
  end

  // Monitor: pops the scoreboard on every beat, update request and done pulse.
  initial begin
    int sweep_beat = 0;
    bit prev_valid = 1'b0;
    bit prev_req = 1'b0;
    int held_ij = 0;
    ev_t e;
    bit ok;
    forever begin
      @(negedge clk);
      if (rst) begin
        sweep_beat = 0;
        prev_valid = 1'b0;
        prev_req = 1'b0;
      end else begin
        if (piv_rst) begin
          piv_rst_cnt++;
          sweep_beat = 0;
        end
        if (piv_valid) begin
          beats_seen++;
          if (sweep_beat != 0) checkOutput("beat contiguity", int'(prev_valid), 1);
          popExpect(EV_BEAT, e, ok);
          if (ok) checkOutput("piv_data", int'(piv_data), e.a);
          sweep_beat++;
          if (sweep_beat == NN) last_beat_cyc = cyc;
        end
        if (upd_req) begin
          if (!prev_req) begin
            upd_cnt++;
            popExpect(EV_UPD, e, ok);
            if (ok) begin
              checkOutput("upd_i", int'(upd_i), e.a);
              checkOutput("upd_j", int'(upd_j), e.b);
            end
            held_ij = int'({upd_i, upd_j});
          end else begin
            checkOutput("upd_ij stable", int'({upd_i, upd_j}), held_ij);
          end
        end
        if (ack_seen_q) checkOutput("upd_req after ack", int'(upd_req), 0);
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          popExpect(EV_DONE, e, ok);
          if (ok) begin
            checkOutput("err at done", int'(err), e.a);
            checkOutput("iter_cnt at done", int'(iter_cnt), e.b);
          end
        end
        prev_valid = piv_valid;
        prev_req = upd_req;
      end
    end
  end

  task automatic pushSweep(input int nbeats);
    for (int k = 0; k < nbeats; k++) exp_q.push_back('{kind: EV_BEAT, a: int'(mem_arr[k]), b: 0});
  endtask

  // One run: iters = clamped request; pon=0 models a silent pivot finder (timeout).
  task automatic applyStimulus(input int nin, input int iters, input bit pon, input bit inject);
    int base_done, base_rst, base_upd, base_beats, sweeps, waited;
    bit injected;
    base_done = done_cnt;
    base_rst = piv_rst_cnt;
    base_upd = upd_cnt;
    base_beats = beats_seen;
    injected = 1'b0;
    piv_on = pon;
    sweeps = pon ? iters : ((iters > 0) ? 1 : 0);
    for (int it = 0; it < sweeps; it++) begin
      pushSweep(NN);
      if (pon) exp_q.push_back('{kind: EV_UPD, a: 2, b: 1});
    end
    exp_q.push_back('{kind: EV_DONE, a: pon ? 0 : 1, b: pon ? iters : 0});

    @(posedge clk); #1;
    start = 1'b1;
    n_iter = CW'(nin);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy after start", int'(busy), 1);
    waited = 0;
    while (done_cnt == base_done && waited < BUDGET) begin
      @(posedge clk); #1;
      waited++;
      if (inject && !injected && beats_seen - base_beats >= 4) begin
        start = 1'b1;
        inject_ack = 1'b1;
        injected = 1'b1;
      end else begin
        start = 1'b0;
        inject_ack = 1'b0;
      end
    end
    start = 1'b0;
    inject_ack = 1'b0;
    checkOutput("done within budget", done_cnt - base_done, 1);
    checkOutput("busy after done", int'(busy), 0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("single done", done_cnt - base_done, 1);
    checkOutput("piv_rst pulses", piv_rst_cnt - base_rst, sweeps);
    checkOutput("beat count", beats_seen - base_beats, sweeps * NN);
    checkOutput("upd handshakes", upd_cnt - base_upd, pon ? iters : 0);
    checkOutput("scoreboard drained", exp_q.size(), 0);
  endtask

  initial begin
    int base_done, base_beats, waited;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst busy", int'(busy), 0);
    checkOutput("rst done", int'(done), 0);
    checkOutput("rst err", int'(err), 0);
    checkOutput("rst piv_valid", int'(piv_valid), 0);
    checkOutput("rst upd_req", int'(upd_req), 0);
    checkOutput("rst piv_rst", int'(piv_rst), 1);
    checkOutput("rst mem_addr", int'(mem_addr), 0);
    checkOutput("rst piv_data", int'(piv_data), 0);
    checkOutput("rst upd_ij", int'({upd_i, upd_j}), 0);
    checkOutput("rst iter_cnt", int'(iter_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-rst piv_rst", int'(piv_rst), 0);
    checkOutput("post-rst busy", int'(busy), 0);

    $display("[TB] single iteration");
    applyStimulus(1, 1, 1'b1, 1'b0);

    $display("[TB] three iterations");
    applyStimulus(3, 3, 1'b1, 1'b0);

    $display("[TB] pivot timeout");
    applyStimulus(2, 2, 1'b0, 1'b0);
    checkOutput("timeout done delay", done_cyc - last_beat_cyc, TIMEOUT + 1);

    $display("[TB] zero iterations");
    applyStimulus(0, 0, 1'b1, 1'b0);
    checkOutput("zero-iter done delay", done_cyc - start_cyc, 1);

    $display("[TB] clamped iterations");
    applyStimulus(15, MAX_ITER, 1'b1, 1'b0);

    $display("[TB] reset mid-sweep");
    piv_on = 1'b1;
    base_done = done_cnt;
    base_beats = beats_seen;
    pushSweep(7);
    @(posedge clk); #1;
    start = 1'b1;
    n_iter = CW'(1);
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (beats_seen - base_beats < 7 && waited < BUDGET) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("reached beat 7", beats_seen - base_beats, 7);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("piv_valid after rst", int'(piv_valid), 0);
    checkOutput("busy in rst", int'(busy), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("busy after rst", int'(busy), 0);
    checkOutput("piv_rst after rst", int'(piv_rst), 0);
    checkOutput("no done on abort", done_cnt - base_done, 0);
    checkOutput("abort scoreboard", exp_q.size(), 0);
    applyStimulus(1, 1, 1'b1, 1'b0);

    $display("[TB] start and ack injected during READ");
    applyStimulus(1, 1, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
